// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one word-aligned request at a time to
// instruction memory, holds the returned word for decode until it is
// accepted, and redirects on branch_taken. Words returned for a request
// that was overtaken by a branch (or by reset) are never presented.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding, its data will be kept
    FLUSH = 2'd1,  // request outstanding, its data will be thrown away
    HOLD  = 2'd2   // word held for decode, no request outstanding
  } state_t;

  localparam logic [31:0] START_PC = RESET_PC & ~32'd3;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  state_t      state_q;
  // Address of the next instruction to be kept (the redirect target once
  // a branch has been seen).
  logic [31:0] fetch_pc_q;
  // Address of the request currently on the bus. Separate from fetch_pc_q
  // because a FLUSH must keep the old address stable until it is acked.
  logic [31:0] addr_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  logic [31:0] target_d;
  logic [31:0] seq_pc_d;
  logic [31:0] flush_pc_d;

  // Aligned redirect target, sequential successor, and latest-wins target.
  always_comb begin
    target_d   = branch_target & ~32'd3;
    seq_pc_d   = pc_q + 32'd4;
    flush_pc_d = branch_taken ? target_d : fetch_pc_q;
  end

  // Request is suppressed combinationally while reset is held so nothing
  // is issued during the reset cycle regardless of the previous state.
  assign mem_req     = ~rst & (state_q != HOLD);
  assign mem_addr    = addr_q;
  assign inst_valid  = valid_q;
  assign instruction = instr_q;
  assign pc          = pc_q;

  // Fetch control FSM with registered address and output words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= START_PC;
      addr_q     <= START_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSN;
      pc_q       <= 32'h0000_0000;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ack) begin
            if (branch_taken) begin
              // Returned word is stale; reissue at the target next cycle.
              fetch_pc_q <= target_d;
              addr_q     <= target_d;
            end else begin
              instr_q <= mem_rdata;
              pc_q    <= addr_q;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else if (branch_taken) begin
            // Request cannot be withdrawn; wait for it and drop its data.
            fetch_pc_q <= target_d;
            state_q    <= FLUSH;
          end
        end
        FLUSH: begin
          fetch_pc_q <= flush_pc_d;
          if (mem_ack) begin
            addr_q  <= flush_pc_d;
            state_q <= FETCH;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            valid_q    <= 1'b0;
            fetch_pc_q <= target_d;
            addr_q     <= target_d;
            state_q    <= FETCH;
          end else if (inst_ready) begin
            valid_q    <= 1'b0;
            fetch_pc_q <= seq_pc_d;
            addr_q     <= seq_pc_d;
            state_q    <= FETCH;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by a randomized run
// against an architectural model (expected next presented PC and a
// deterministic memory image).
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;

  int vectors;
  int miscompares;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .instruction  (instruction),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each word is a fixed scramble of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic do_reset;
    rst = 1'b1; mem_ack = 1'b0; branch_taken = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    branch_taken = 1'b0; branch_target = 32'h0; inst_ready = 1'b0;
    @(negedge clk);
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    vectors++; if (instruction !== 32'h13) begin miscompares++; $display("FAIL rst_insn: got %h want 00000013", instruction); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 00000000", pc); end
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin miscompares++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RST_PC); end
  endtask

  task automatic test_first_fetch;
    do_reset();
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL ff_addr: got %h want 00000100", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL ff_valid: got %b want 1", inst_valid); end
    vectors++; if (instruction !== 32'h0050_0093) begin miscompares++; $display("FAIL ff_insn: got %h want 00500093", instruction); end
    vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL ff_pc: got %h want 00000100", pc); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL ff_req: got %b want 0", mem_req); end
  endtask

  task automatic test_hold_stall;
    inst_ready = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (inst_valid !== 1'b1 || instruction !== 32'h0050_0093 || pc !== 32'h100 || mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_%0d: got v=%b insn=%h pc=%h req=%b want v=1 insn=00500093 pc=00000100 req=0",
                 i, inst_valid, instruction, pc, mem_req);
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL stall_next: got req=%b addr=%h v=%b want req=1 addr=00000104 v=0", mem_req, mem_addr, inst_valid); end
  endtask

  task automatic test_branch_flush;
    do_reset();
    // cycle 0: request at 0x100, no ack
    @(negedge clk);
    // cycle 1: branch while request outstanding
    branch_taken = 1'b1; branch_target = 32'h203;
    @(negedge clk);
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL flush_hold_%0d: got req=%b addr=%h v=%b want req=1 addr=00000100 v=0", i, mem_req, mem_addr, inst_valid); end
      if (i == 0) @(negedge clk);
    end
    // cycle 3: late ack of the stale request
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL flush_redirect: got req=%b addr=%h v=%b want req=1 addr=00000200 v=0", mem_req, mem_addr, inst_valid); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || pc !== 32'h200 || instruction !== 32'h1111_1111) begin miscompares++; $display("FAIL flush_target: got v=%b pc=%h insn=%h want v=1 pc=00000200 insn=11111111", inst_valid, pc, instruction); end
  endtask

  task automatic test_hold_branch;
    branch_taken = 1'b1; branch_target = 32'h40; inst_ready = 1'b1;
    @(negedge clk);
    branch_taken = 1'b0; inst_ready = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL hold_branch: got v=%b req=%b addr=%h want v=0 req=1 addr=00000040", inst_valid, mem_req, mem_addr); end
  endtask

  task automatic test_wrap;
    mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || pc !== 32'h40) begin miscompares++; $display("FAIL wrap_pc40: got v=%b pc=%h want v=1 pc=00000040", inst_valid, pc); end
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    vectors++; if (mem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_align: got addr=%h v=%b want addr=fffffffc v=0", mem_addr, inst_valid); end
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top: got v=%b pc=%h want v=1 pc=fffffffc", inst_valid, pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_zero: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid;
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333; rst = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b0 || instruction !== 32'h13 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_state: got v=%b insn=%h req=%b want v=0 insn=00000013 req=0", inst_valid, instruction, mem_req); end
    rst = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin miscompares++; $display("FAIL rstmid_addr: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RST_PC); end
    @(negedge clk);
    #1;
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_noack: got v=%b want 0", inst_valid); end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pend;
    int          lat;
    int          idle;
    int          handshakes;
    do_reset();
    exp_pc = RST_PC; pend = 1'b0; pend_addr = 32'h0; lat = 0; idle = 0; handshakes = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      #1;
      // protocol checks on the request side
      if (rst) begin
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rnd_rst_req c=%0d: got %b want 0", c, mem_req); end
      end else if (mem_req === 1'b1) begin
        vectors++; if (mem_addr[1:0] !== 2'b00) begin miscompares++; $display("FAIL rnd_align c=%0d: got addr=%h", c, mem_addr); end
        if (pend) begin
          vectors++; if (mem_addr !== pend_addr) begin miscompares++; $display("FAIL rnd_addr_stable c=%0d: got %h want %h", c, mem_addr, pend_addr); end
        end
      end
      // presented instruction must be the next one in program order
      if (inst_valid === 1'b1) begin
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rnd_req_in_hold c=%0d: got req=%b want 0", c, mem_req); end
        vectors++; if (pc !== exp_pc) begin miscompares++; $display("FAIL rnd_pc c=%0d: got %h want %h", c, pc, exp_pc); end
        vectors++; if (instruction !== mem_word(exp_pc)) begin miscompares++; $display("FAIL rnd_insn c=%0d: got %h want %h", c, instruction, mem_word(exp_pc)); end
      end
      // stimulus for the coming edge
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      inst_ready    = $urandom_range(0, 1);
      if (rst) begin
        mem_ack   = $urandom_range(0, 1);
        mem_rdata = $urandom;
        lat       = 0;
      end else if (mem_req === 1'b1) begin
        if (lat == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          lat       = $urandom_range(0, 3);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          lat--;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      pend      = !rst && (mem_req === 1'b1) && !mem_ack;
      pend_addr = mem_addr;
      // architectural effect of this edge
      idle++;
      if (rst) begin
        exp_pc = RST_PC;
        idle   = 0;
      end else if (branch_taken) begin
        exp_pc = branch_target & ~32'd3;
      end else if (inst_valid === 1'b1 && inst_ready) begin
        exp_pc = exp_pc + 32'd4;
        handshakes++;
        idle = 0;
      end
      if (idle > 300) begin
        vectors++; miscompares++;
        $display("FAIL rnd_progress c=%0d: got no handshake for %0d cycles want under 300", c, idle);
        idle = 0;
      end
    end
    vectors++; if (handshakes < 200) begin miscompares++; $display("FAIL rnd_throughput: got %0d handshakes want at least 200", handshakes); end
    rst = 1'b0; branch_taken = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0; inst_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_branch_flush();
    test_hold_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be treated as 0).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: mem_req  output  1  instruction memory request, held high until mem_ack.
REQ-006 Port: mem_addr  output  32  word-aligned fetch address; stable while mem_req=1.
REQ-007 Port: mem_ack  input  1  request complete; mem_rdata valid in the same cycle.
REQ-008 Port: mem_rdata  input  32  instruction word from memory.
REQ-009 Port: branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-010 Port: branch_target  input  32  redirect address; bits [1:0] SHALL be forced to 0.
REQ-011 Port: inst_valid  output  1  instruction/pc valid to the decode/ALU stage.
REQ-012 Port: inst_ready  input  1  downstream accepts instruction this cycle.
REQ-013 Port: instruction  output  32  fetched instruction word, registered.
REQ-014 Port: pc  output  32  address of instruction, registered.

Function
REQ-015 The block SHALL implement states FETCH, FLUSH, HOLD, with a registered next-fetch address fetch_pc.
REQ-016 FETCH: mem_req=1, mem_addr=fetch_pc; on mem_ack without branch_taken, instruction<=mem_rdata, pc<=fetch_pc, go HOLD.
REQ-017 HOLD: mem_req=0, inst_valid=1; instruction and pc SHALL stay stable until handshake (inst_valid & inst_ready).
REQ-018 HOLD on handshake without branch: fetch_pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go FETCH.
REQ-019 Minimum latency: mem_ack in first FETCH cycle -> inst_valid=1 next cycle; sustained throughput one instruction per 2 cycles.
REQ-020 Only one memory request SHALL be outstanding; mem_addr SHALL NOT change while mem_req=1 and mem_ack=0.
REQ-021 branch_taken in FETCH with mem_ack=1 same cycle: mem_rdata discarded, fetch_pc<=target, stay FETCH (new request next cycle).
REQ-022 branch_taken in FETCH with mem_ack=0: fetch_pc<=target, go FLUSH; FLUSH keeps mem_req=1 at old address, discards data on mem_ack, then goes FETCH.
REQ-023 branch_taken in FLUSH: fetch_pc<=new target (latest wins), remain FLUSH until ack (or go FETCH if ack same cycle).
REQ-024 branch_taken in HOLD (with or without inst_ready): inst_valid<=0 next cycle, fetch_pc<=target, go FETCH; held instruction SHALL be dropped.
REQ-025 inst_valid SHALL be 0 in FETCH and FLUSH; a discarded word SHALL never be presented.

Reset
REQ-026 While rst=1 at a clock edge: state<=FETCH, fetch_pc<=RESET_PC, inst_valid<=0, instruction<=32'h0000_0013 (NOP), pc<=0; mem_req SHALL be 0 during the reset cycle.
REQ-027 First cycle after rst deasserts: mem_req=1, mem_addr=RESET_PC.
REQ-028 Reset mid-request (FETCH/FLUSH/HOLD) SHALL abandon the request; a mem_ack arriving in the reset cycle SHALL be ignored.

Verification
REQ-029 Reset RESET_PC=0x100, memory acks immediately with 0x00500093 -> mem_addr=0x100, next cycle inst_valid=1, instruction=0x00500093, pc=0x100.
REQ-030 inst_ready low 5 cycles in HOLD -> instruction/pc unchanged, mem_req=0; on ready -> next mem_addr=0x104.
REQ-031 Memory ack delayed 3 cycles, branch_taken target 0x203 in cycle 1 -> mem_addr stays 0x100 until ack, data discarded, next mem_addr=0x200, inst_valid never high for 0x100.
REQ-032 branch_taken to 0x40 in HOLD with inst_ready=1 -> inst_valid=0 next cycle, next mem_addr=0x40.
REQ-033 pc=0xFFFF_FFFC handshake -> next mem_addr=0x0000_0000.
REQ-034 rst asserted during outstanding request with mem_ack same cycle -> inst_valid=0, instruction=0x13, next mem_addr=RESET_PC.
